clk_div_bank: RTL
=================

Name: clk_div_bank

Overview:
- Parametrised successor to the single fixed divide-by-2 `clk_50` generator.
- Provides NCH independent clock dividers, all driven from the one system clock `clkin`.
- Each channel has a runtime-programmable divisor and produces two outputs: a divided clock (`clk_out`) for slow logic/IO and a one-cycle enable pulse (`tick`) for game-timing logic.
- Divisor changes apply glitch-free at the period boundary. A global resync aligns all channel phases.

Parameters:
- NCH, 4: number of divider channels (1..16).
- CW, 16: divisor/counter width in bits.
- DEF_DIV, 2: divisor loaded into every channel at reset (1..2^CW-1).
- CHW, $clog2(NCH) min 1: width of the channel-select field (derived; not user-set).

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ch_en  in  NCH  per-channel run enable.
- resync  in  1  single-cycle pulse; restarts all channels at phase 0.
- cfg_wr  in  1  divisor write strobe (one cycle).
- cfg_ch  in  CHW  target channel for cfg_wr.
- cfg_div  in  CW  new divisor; 0 is treated as 1.
- cfg_ack  out  NCH  one-cycle pulse per channel when a pending divisor becomes active.
- clk_out  out  NCH  divided clock per channel.
- tick  out  NCH  one-cycle pulse per channel, once per period.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Per channel: cnt=0, active div D=DEF_DIV, pending flag clear.
  - Outputs: clk_out=0, tick=0, cfg_ack=0.
  - Outputs clear immediately, without a clock edge.
- Per-channel counter:
  - cnt is CW bits and runs 0..D-1.
  - On each edge with ch_en[i]=1: cnt<=(cnt==D-1)?0:cnt+1.
- Outputs are registered from the pre-edge cnt (1-cycle latency):
  - clk_out[i] <= (cnt < floor(D/2)).
  - tick[i] <= (cnt == D-1).
  - Result: tick is high exactly 1 cycle in every D.
  - clk_out is high floor(D/2) cycles and low D-floor(D/2) cycles. D=2 gives clkin/2 at 50% duty.
  - D=1: clk_out is constantly 0 and tick is constantly 1.
- After reset release, all channels enabled:
  - First tick asserts after the D-th edge.
  - clk_out first rises after the 1st edge (when D>=2).
- Configuration:
  - cfg_wr loads cfg_div (0 mapped to 1) into channel cfg_ch's pending register and sets its pending flag.
  - A later write before apply overwrites the pending value; only one ack is produced.
  - cfg_ch >= NCH: write ignored, no ack.
- Apply rules:
  - Enabled channel: pending applies on the wrap edge (cnt==D-1). That edge sets cnt<=0 and D<=pending, clears the flag, and pulses cfg_ack[i] for the following cycle.
  - The old period always completes, so there are no runt pulses.
  - Disabled channel: pending applies on the next edge.
  - A write arriving on the same edge as the wrap is not applied until the next wrap, except when resync is also active (see below).
- Disable (ch_en[i]=0):
  - cnt<=0; clk_out[i]<=0; tick[i]<=0; counter frozen.
  - On re-enable, the channel restarts from phase 0, identical to post-reset timing.
- Resync (pulse, edge-sampled):
  - Every channel: cnt<=0, clk_out<=0, tick<=0.
  - Every pending divisor applies, including a cfg_wr in the same cycle; cfg_ack pulses for each.
  - After resync, enabled channels with equal D produce coincident ticks.
- Priority per channel: rst_n > resync > ch_en=0 > wrap/apply > count.
- Multiple channels may ack in the same cycle; cfg_ack is a vector for this reason.

Test Plan:
1. Reset, ch_en=4'hF, DEF_DIV=2, release rst_n:
   - Required: clk_out[0..3] toggle every clkin cycle.
   - Required: tick pulses every 2 cycles, first after edge 2.
2. All enabled. Write ch1 D=5 while ch1 cnt=0:
   - Required: ch1 finishes its old 2-cycle period.
   - Required: cfg_ack[1] pulses once at the wrap.
   - Required: thereafter clk_out[1] is high 2, low 3, and tick[1] has period 5.
   - Required: other channels unchanged.
3. Write ch2 D=0, then ch3 D=1:
   - Required: both channels show tick=1 every cycle and clk_out=0.
   - Required: one ack each.
4. ch_en[0]=0 mid-period, write ch0 D=7:
   - Required: cfg_ack[0] next cycle; clk_out[0]/tick[0] at 0.
   - Required: on re-enable, first tick[0] after the 7th edge.
5. Channels at D=3, 4, 6 with arbitrary phases; pulse resync:
   - Required: all cnt reset.
   - Required: ticks at edges 3/4/6 after resync; coincident ticks at edge 12 (ch D=3, D=4, D=6) and every 12 thereafter.
6. Mid-operation rst_n low between clock edges:
   - Required: all outputs 0 immediately.
   - Required: pending write discarded; D returns to DEF_DIV after release.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH runtime-programmable clock dividers with tick pulses
//   clkin, rst_n              system clock, asynchronous active-low reset
//   ch_en[NCH]                per-channel run enable; a disabled channel sits at phase 0
//   resync                    restarts every channel at phase 0 and applies pending divisors
//   cfg_wr, cfg_ch, cfg_div   divisor write strobe, target channel, divisor (0 treated as 1)
//   cfg_ack[NCH]              one-cycle pulse when a pending divisor takes effect
//   clk_out[NCH], tick[NCH]   divided clock and once-per-period enable pulse
module clk_div_bank #(
    parameter int NCH = 4,
    parameter int CW = 16,
    parameter int DEF_DIV = 2,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clkin,
    input  logic           rst_n,
    input  logic [NCH-1:0] ch_en,
    input  logic           resync,
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic [NCH-1:0] cfg_ack,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);
    logic [CW-1:0] wr_div;
    assign wr_div = (cfg_div == '0) ? CW'(1) : cfg_div;
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d, div_q, div_d, pdiv_q, pdiv_d;
        logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, ack_q, ack_d;
        logic wr, wrap, run, apply;
        assign wr = cfg_wr && (cfg_ch == CHW'(i));
        assign wrap = cnt_q == div_q - CW'(1);
        assign run = !resync && ch_en[i];
        // An enabled channel holds a pending divisor until its wrap so the running
        // period always completes; resync also takes a write from the same cycle.
        assign apply = resync ? (pend_q || wr) : (pend_q && (!ch_en[i] || wrap));
        always_comb begin
            cnt_d = (!run || wrap) ? '0 : cnt_q + CW'(1);
            clk_d = run && (cnt_q < (div_q >> 1));
            tick_d = run && wrap;
            ack_d = apply;
            div_d = apply ? ((resync && wr) ? wr_div : pdiv_q) : div_q;
            pend_d = !resync && (wr || (pend_q && !apply));
            pdiv_d = wr ? wr_div : pdiv_q;
        end
        always_ff @(posedge clkin or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                div_q <= CW'(DEF_DIV);
                pdiv_q <= '0;
                pend_q <= 1'b0;
                clk_q <= 1'b0;
                tick_q <= 1'b0;
                ack_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                div_q <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                clk_q <= clk_d;
                tick_q <= tick_d;
                ack_q <= ack_d;
            end
        end
        assign clk_out[i] = clk_q;
        assign tick[i] = tick_q;
        assign cfg_ack[i] = ack_q;
    end
endmodule
